// File: rtl/alu_op_sequencer.sv
// Control FSM that sequences register-file reads, ALU execution and writeback.
// Optional ALU_SEQ_CMP_EN: compare commands skip writeback and only update status.
module alu_op_sequencer #(
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s,
    input  logic [1:0]      op,
    input  logic            cmp,
    input  logic [RA_W-1:0] rd,
    input  logic [RA_W-1:0] rn,
    input  logic [RA_W-1:0] rm,
    output logic            w,
    output logic [RA_W-1:0] readnum,
    output logic [RA_W-1:0] writenum,
    output logic            write,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic [1:0]      ALUop
);

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        WB    = 3'd4
    } state_t;

    localparam logic [1:0] OP_MVN = 2'b11;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [RA_W-1:0] rn_q, rn_d;
    logic [RA_W-1:0] rm_q, rm_d;
    logic            cmp_q, cmp_d;

    logic            w_q, write_q, loada_q, loadb_q, loadc_q, loads_q, asel_q;
    logic [RA_W-1:0] readnum_q, writenum_q;
    logic [1:0]      aluop_q;

`ifndef ALU_SEQ_CMP_EN
    logic cmp_unused;
    assign cmp_unused = cmp;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        cmp_d   = cmp_q;
        case (state_q)
            WAIT: begin
                if (s) begin
                    op_d    = op;
                    rd_d    = rd;
                    rn_d    = rn;
                    rm_d    = rm;
`ifdef ALU_SEQ_CMP_EN
                    cmp_d   = cmp;
`else
                    cmp_d   = 1'b0;
`endif
                    state_d = (op == OP_MVN) ? GET_B : GET_A;
                end
            end
            GET_A:   state_d = GET_B;
            GET_B:   state_d = EXEC;
            EXEC:    state_d = cmp_q ? WAIT : WB;
            WB:      state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // still line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT;
            op_q       <= '0;
            rd_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            cmp_q      <= 1'b0;
            w_q        <= 1'b1;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            aluop_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            cmp_q      <= cmp_d;
            w_q        <= (state_d == WAIT);
            loada_q    <= (state_d == GET_A);
            loadb_q    <= (state_d == GET_B);
            loadc_q    <= (state_d == EXEC);
            loads_q    <= (state_d == EXEC);
            write_q    <= (state_d == WB);
            asel_q     <= (state_d == EXEC) && (op_d == OP_MVN);
            readnum_q  <= (state_d == GET_A) ? rn_d :
                          (state_d == GET_B) ? rm_d : '0;
            writenum_q <= (state_d == WB) ? rd_d : '0;
            aluop_q    <= ((state_d == EXEC) || (state_d == WB)) ? op_d : '0;
        end
    end

    assign w        = w_q;
    assign write    = write_q;
    assign loada    = loada_q;
    assign loadb    = loadb_q;
    assign loadc    = loadc_q;
    assign loads    = loads_q;
    assign asel     = asel_q;
    assign readnum  = readnum_q;
    assign writenum = writenum_q;
    assign ALUop    = aluop_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer; expectations follow ALU_SEQ_CMP_EN.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset, s, cmp;
    logic [1:0] op;
    logic [2:0] rd, rn, rm;
    logic       w, write, loada, loadb, loadc, loads, asel;
    logic [2:0] readnum, writenum;
    logic [1:0] ALUop;

    int tests = 0;
    int fails = 0;

    // {w, loada, loadb, loadc, loads, write, asel, readnum, writenum, ALUop}
    logic [14:0] obs;
    assign obs = {w, loada, loadb, loadc, loads, write, asel, readnum, writenum, ALUop};

    localparam logic [14:0] V_WAIT = {7'b1000000, 3'd0, 3'd0, 2'd0};

    alu_op_sequencer #(.RA_W(3)) dut (
        .clk(clk), .reset(reset), .s(s), .op(op), .cmp(cmp),
        .rd(rd), .rn(rn), .rm(rm),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .ALUop(ALUop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s = 1'b1; op = 2'b00; cmp = 1'b0; rd = 3'd1; rn = 3'd2; rm = 3'd3;
        step();
        reset = 1'b0; s = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            tests++;
            if (obs !== V_WAIT) begin
                fails++;
                $display("FAIL reset cyc%0d: got %b expected %b", i, obs, V_WAIT);
            end
            step();
        end
    endtask

    task automatic test_add();
        logic [14:0] exp [5];
        exp[0] = {7'b0100000, 3'd1, 3'd0, 2'd0};
        exp[1] = {7'b0010000, 3'd2, 3'd0, 2'd0};
        exp[2] = {7'b0001100, 3'd0, 3'd0, 2'd0};
        exp[3] = {7'b0000010, 3'd0, 3'd3, 2'd0};
        exp[4] = V_WAIT;
        s = 1'b1; op = 2'b00; cmp = 1'b0; rn = 3'd1; rm = 3'd2; rd = 3'd3;
        step();
        s = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL add cyc%0d: got %b expected %b", i, obs, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_mvn();
        logic [14:0] exp [4];
        exp[0] = {7'b0010000, 3'd5, 3'd0, 2'd0};
        exp[1] = {7'b0001101, 3'd0, 3'd0, 2'd3};
        exp[2] = {7'b0000010, 3'd0, 3'd0, 2'd3};
        exp[3] = V_WAIT;
        s = 1'b1; op = 2'b11; cmp = 1'b0; rn = 3'd7; rm = 3'd5; rd = 3'd0;
        step();
        s = 1'b0; op = 2'b00; rm = 3'd1; rd = 3'd6;
        for (int unsigned i = 0; i < 4; i++) begin
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL mvn cyc%0d: got %b expected %b", i, obs, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_compare();
        logic [14:0] exp [5];
        int unsigned n;
        exp[0] = {7'b0100000, 3'd4, 3'd0, 2'd0};
        exp[1] = {7'b0010000, 3'd6, 3'd0, 2'd0};
        exp[2] = {7'b0001100, 3'd0, 3'd0, 2'd1};
`ifdef ALU_SEQ_CMP_EN
        exp[3] = V_WAIT;
        exp[4] = V_WAIT;
        n = 5;
`else
        exp[3] = {7'b0000010, 3'd0, 3'd2, 2'd1};
        exp[4] = V_WAIT;
        n = 5;
`endif
        s = 1'b1; op = 2'b01; cmp = 1'b1; rn = 3'd4; rm = 3'd6; rd = 3'd2;
        step();
        s = 1'b0; cmp = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL compare cyc%0d: got %b expected %b", i, obs, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_in_exec();
        int unsigned wr_seen;
        s = 1'b1; op = 2'b00; cmp = 1'b0; rn = 3'd1; rm = 3'd2; rd = 3'd5;
        step();
        s = 1'b0;
        step();
        step();
        tests++;
        if (obs !== {7'b0001100, 3'd0, 3'd0, 2'd0}) begin
            fails++;
            $display("FAIL rst_exec pre: got %b expected %b", obs, {7'b0001100, 3'd0, 3'd0, 2'd0});
        end
        reset = 1'b1; s = 1'b1;
        step();
        reset = 1'b0; s = 1'b0;
        wr_seen = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            tests++;
            if (obs !== V_WAIT) begin
                fails++;
                $display("FAIL rst_exec cyc%0d: got %b expected %b", i, obs, V_WAIT);
            end
            if (write) wr_seen++;
            step();
        end
        tests++;
        if (wr_seen !== 0) begin
            fails++;
            $display("FAIL rst_exec write_count: got %0d expected 0", wr_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp [11];
        exp[0]  = {7'b0100000, 3'd3, 3'd0, 2'd0};
        exp[1]  = {7'b0010000, 3'd4, 3'd0, 2'd0};
        exp[2]  = {7'b0001100, 3'd0, 3'd0, 2'd2};
        exp[3]  = {7'b0000010, 3'd0, 3'd6, 2'd2};
        exp[4]  = V_WAIT;
        exp[5]  = {7'b0100000, 3'd1, 3'd0, 2'd0};
        exp[6]  = {7'b0010000, 3'd2, 3'd0, 2'd0};
        exp[7]  = {7'b0001100, 3'd0, 3'd0, 2'd0};
        exp[8]  = {7'b0000010, 3'd0, 3'd7, 2'd0};
        exp[9]  = V_WAIT;
        exp[10] = V_WAIT;
        s = 1'b1; op = 2'b10; cmp = 1'b0; rn = 3'd3; rm = 3'd4; rd = 3'd6;
        step();
        op = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd7;
        for (int unsigned i = 0; i < 11; i++) begin
            tests++;
            if (obs !== exp[i]) begin
                fails++;
                $display("FAIL b2b cyc%0d: got %b expected %b", i, obs, exp[i]);
            end
            if (i == 8) s = 1'b0;
            step();
        end
    endtask

    initial begin
        reset = 1'b0; s = 1'b0; op = '0; cmp = 1'b0; rd = '0; rn = '0; rm = '0;
        #2;
        test_reset();
        test_add();
        test_mvn();
        test_compare();
        test_reset_in_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: RA_W, 3, register-file address width (8 registers).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: s  input  1  start request; qualified only while w=1.
REQ-005 Port: op  input  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 MVN (NOT Bin).
REQ-006 Port: cmp  input  1  compare command: update status only, no writeback.
REQ-007 Port: rd, rn, rm  input  RA_W each  destination, A-source and B-source register numbers.
REQ-008 Port: w  output  1  idle/ready; high only in WAIT.
REQ-009 Port: readnum  output  RA_W  register-file read address.
REQ-010 Port: writenum  output  RA_W  register-file write address.
REQ-011 Port: write  output  1  register-file write enable.
REQ-012 Port: loada, loadb, loadc, loads  output  1 each  load enables for A, B, result C and status (Z,V,N) registers.
REQ-013 Port: asel  output  1  1 forces ALU Ain to 16'b0.
REQ-014 Port: ALUop  output  2  operation driven to the ALU.

Function
REQ-015 The FSM SHALL have states WAIT, GET_A, GET_B, EXEC, WB; all outputs are Moore-decoded from state and the latched command.
REQ-016 In WAIT with s=1, the block SHALL latch op, cmp, rd, rn, rm and go to GET_A; for op=11, it SHALL go directly to GET_B.
REQ-017 s SHALL be ignored in every state other than WAIT; latched fields SHALL NOT change until the next acceptance.
REQ-018 GET_A: readnum=rn, loada=1; next state GET_B.
REQ-019 GET_B: readnum=rm, loadb=1; next state EXEC.
REQ-020 EXEC: ALUop=latched op, loadc=1, loads=1; asel=1 only for op=11; next state WB, or WAIT when the compare command is active (REQ-031).
REQ-021 WB: writenum=rd, write=1, ALUop held; next state WAIT.
REQ-022 Outputs not named for a state SHALL be 0, with readnum, writenum and ALUop at 0 outside their states except ALUop in WB.
REQ-023 Latency from accept edge to w=1: ADD/SUB/AND 4 cycles; MVN 3 cycles; compare 3 cycles.
REQ-024 Back-to-back: s held high SHALL start a new command on the first cycle w=1, with no idle cycle inserted.
REQ-025 write and loads SHALL each pulse for exactly one cycle per accepted command; loads SHALL be 1 exactly once per command.
REQ-026 rd=rn=rm aliasing SHALL need no special handling; reads complete before WB.

Reset
REQ-027 reset=1 SHALL force WAIT at the next edge, overriding s.
REQ-028 After reset: w=1; write, loada, loadb, loadc, loads, asel=0; readnum, writenum, ALUop=0; latched fields 0.
REQ-029 Reset in any non-WAIT state SHALL abort the command with no write pulse after the reset edge.
REQ-030 s sampled high in the same cycle as reset SHALL be discarded.

Configuration
REQ-031 With macro ALU_SEQ_CMP_EN defined, cmp=1 at accept SHALL make EXEC return directly to WAIT, with no WB state and write never asserted.
REQ-032 Without ALU_SEQ_CMP_EN, the cmp port SHALL exist but be ignored, and all commands SHALL execute WB.

Verification
REQ-033 reset for 1 cycle, then idle -> w=1, all enables 0, readnum, writenum and ALUop = 0.
REQ-034 s=1, op=00, rn=1, rm=2, rd=3 -> loada@rn=1, loadb@rm=2, loadc/loads with ALUop=00, write@writenum=3; w=1 four cycles after accept.
REQ-035 s=1, op=11, rm=5, rd=0 -> GET_A skipped, loada never 1, asel=1 in EXEC, write@0; w=1 after 3 cycles.
REQ-036 ALU_SEQ_CMP_EN defined; s=1, op=01, cmp=1 -> loads=1 once, write stays 0; w=1 after 3 cycles. Macro undefined, same stimulus -> write pulses once.
REQ-037 reset asserted during EXEC -> next cycle WAIT, w=1, and write never asserted for that command.
REQ-038 s held high for two commands; inputs toggled mid-command -> second command starts the cycle w=1; first command uses its originally latched fields.
